// File: rtl/mandelbrot_recirc_pkg.sv
// Shared constants for the Mandelbrot recirculation loop: geometry defaults,
// record layout, FSM states and draw-mode codes.
package mandelbrot_recirc_pkg;

  localparam int H_ACTIVE_DEF    = 800;
  localparam int V_ACTIVE_DEF    = 480;
  localparam int PIXEL_COUNT_DEF = H_ACTIVE_DEF * V_ACTIVE_DEF;

  localparam int REC_W    = 104;
  localparam int ADDR_W   = 19;
  localparam int PX_W     = 8;
  localparam int PASS_W   = 16;

  // Record layout: {PxVal, X, Y, Iter}
  localparam int PX_MSB   = 103;
  localparam int PX_LSB   = 96;
  localparam int X_MSB    = 95;
  localparam int X_LSB    = 64;
  localparam int Y_MSB    = 63;
  localparam int Y_LSB    = 32;
  localparam int ITER_MSB = 31;
  localparam int ITER_LSB = 0;

  localparam int CLEAR_CYCLES = 4;

  typedef enum logic [1:0] {
    DRAW_ITER    = 2'd0,
    DRAW_GRAY    = 2'd1,
    DRAW_PALETTE = 2'd2
  } draw_mode_e;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_SEED  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [PX_W-1:0] recPxVal(input logic [REC_W-1:0] rec);
    return rec[PX_MSB:PX_LSB];
  endfunction

endpackage

// File: rtl/mandelbrot_recirc_counter.sv
// Raster position tracker: x/y counters plus a linear framebuffer address
// kept in step incrementally so no multiplier is needed.
module pixel_addr_counter
  import mandelbrot_recirc_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  localparam int XW = cntWidth(H_ACTIVE),
  localparam int YW = cntWidth(V_ACTIVE)
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Advance,
  input  logic              i_Clear,
  output logic [XW-1:0]     o_X,
  output logic [YW-1:0]     o_Y,
  output logic [ADDR_W-1:0] o_Addr,
  output logic              o_Last
);

  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              lastX, lastY;

  assign lastX = (x_q == XW'(H_ACTIVE - 1));
  assign lastY = (y_q == YW'(V_ACTIVE - 1));

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (i_Clear) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (i_Advance) begin
      addr_d = addr_q + 1'b1;
      if (lastX) begin
        x_d = '0;
        if (lastY) begin
          y_d    = '0;
          addr_d = '0;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign o_X    = x_q;
  assign o_Y    = y_q;
  assign o_Addr = addr_q;
  assign o_Last = lastX & lastY;

endmodule

// File: rtl/mandelbrot_recirc.sv
// Recirculation controller: clears the FIFOs, seeds one zero record per pixel,
// then loops results back into the math stage while writing pixels out.
module mandelbrot_recirc
  import mandelbrot_recirc_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic [REC_W-1:0]  i_Result_Data,
  input  logic              i_Result_Empty,
  output logic              o_Result_Rdack,
  input  logic              i_Feed_Full,
  output logic              o_Feed_Wrreq,
  output logic [REC_W-1:0]  o_Feed_Data,
  output logic              o_Fifo_Aclr,
  output logic              o_Fb_We,
  output logic [ADDR_W-1:0] o_Fb_Addr,
  output logic [PX_W-1:0]   o_Fb_Data,
  output logic              o_Pass_Done,
  output logic [PASS_W-1:0] o_Pass_Count
);

  localparam int PIXEL_COUNT = H_ACTIVE * V_ACTIVE;
  localparam int XW          = cntWidth(H_ACTIVE);
  localparam int YW          = cntWidth(V_ACTIVE);
  localparam int CLR_W       = cntWidth(CLEAR_CYCLES);

  state_e              state_q, state_d;
  logic [CLR_W-1:0]    clearCnt_q;
  logic [ADDR_W-1:0]   seedCnt_q;
  logic                fbWe_q;
  logic [ADDR_W-1:0]   fbAddr_q;
  logic [PX_W-1:0]     fbData_q;
  logic                passDone_q;
  logic [PASS_W-1:0]   passCount_q;

  logic                fifoAclr, feedWrreq, resultRdack;
  logic [REC_W-1:0]    feedData;
  logic                pixAdvance, pixClear;
  logic                clearDone, seedLast;

  logic [XW-1:0]       pixX;
  logic [YW-1:0]       pixY;
  logic [ADDR_W-1:0]   pixAddr;
  logic                pixLast;
  logic                unusedPixXY;

  pixel_addr_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_pixel_addr_counter (
    .i_Clk     (i_Clk),
    .i_Rst_n   (i_Rst_n),
    .i_Advance (pixAdvance),
    .i_Clear   (pixClear),
    .o_X       (pixX),
    .o_Y       (pixY),
    .o_Addr    (pixAddr),
    .o_Last    (pixLast)
  );

  assign unusedPixXY = ^{pixX, pixY};

  assign clearDone = (clearCnt_q == CLR_W'(CLEAR_CYCLES - 1));
  assign seedLast  = (seedCnt_q == ADDR_W'(PIXEL_COUNT - 1));

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clearDone) state_d = ST_SEED;
      ST_SEED:  if (feedWrreq && seedLast) state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    fifoAclr    = 1'b0;
    feedWrreq   = 1'b0;
    resultRdack = 1'b0;
    feedData    = '0;
    pixAdvance  = 1'b0;
    pixClear    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        fifoAclr = 1'b1;
        pixClear = 1'b1;
      end
      ST_SEED: begin
        feedWrreq  = ~i_Feed_Full;
        pixAdvance = ~i_Feed_Full;
      end
      ST_RUN: begin
        resultRdack = ~i_Result_Empty & ~i_Feed_Full;
        feedWrreq   = ~i_Result_Empty & ~i_Feed_Full;
        feedData    = i_Result_Data;
        pixAdvance  = ~i_Result_Empty & ~i_Feed_Full;
      end
      default: fifoAclr = 1'b1;
    endcase
  end

  // Seed count only moves on accepted pushes so a full feed FIFO never drops or repeats one
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      clearCnt_q <= '0;
      seedCnt_q  <= '0;
    end else begin
      clearCnt_q <= (state_q == ST_CLEAR) ? clearCnt_q + 1'b1 : '0;
      if (state_q == ST_CLEAR) begin
        seedCnt_q <= '0;
      end else if (state_q == ST_SEED && feedWrreq) begin
        seedCnt_q <= seedCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      fbWe_q      <= 1'b0;
      fbAddr_q    <= '0;
      fbData_q    <= '0;
      passDone_q  <= 1'b0;
      passCount_q <= '0;
    end else begin
      fbWe_q     <= resultRdack;
      passDone_q <= resultRdack & pixLast;
      if (resultRdack) begin
        fbAddr_q <= pixAddr;
        fbData_q <= recPxVal(i_Result_Data);
        if (pixLast) begin
          passCount_q <= passCount_q + 1'b1;
        end
      end
    end
  end

  assign o_Fifo_Aclr    = fifoAclr;
  assign o_Feed_Wrreq   = feedWrreq;
  assign o_Feed_Data    = feedData;
  assign o_Result_Rdack = resultRdack;
  assign o_Fb_We        = fbWe_q;
  assign o_Fb_Addr      = fbAddr_q;
  assign o_Fb_Data      = fbData_q;
  assign o_Pass_Done    = passDone_q;
  assign o_Pass_Count   = passCount_q;

endmodule

// File: tb/tb_mandelbrot_recirc.sv
// Directed bench for mandelbrot_recirc on a reduced 16x4 raster so whole
// seed and run passes fit in a short simulation.
module tb_mandelbrot_recirc;

  localparam int H   = 16;
  localparam int V   = 4;
  localparam int PIX = H * V;

  logic         clk = 1'b0;
  logic         rstN;
  logic [103:0] resultData;
  logic         resultEmpty;
  logic         resultRdack;
  logic         feedFull;
  logic         feedWrreq;
  logic [103:0] feedData;
  logic         fifoAclr;
  logic         fbWe;
  logic [18:0]  fbAddr;
  logic [7:0]   fbData;
  logic         passDone;
  logic [15:0]  passCount;

  int nCompared   = 0;
  int nMismatched = 0;

  int       modelPix;
  logic     expFbWe;
  int       expFbAddr;
  logic [7:0] expFbData;
  logic     expPassDone;
  int       expPassCount;

  int aclrCycles, pushes, firstPush, lastPush, badCycles;

  always #5 clk = ~clk;

  mandelbrot_recirc #(
    .H_ACTIVE (H),
    .V_ACTIVE (V)
  ) dut (
    .i_Clk          (clk),
    .i_Rst_n        (rstN),
    .i_Result_Data  (resultData),
    .i_Result_Empty (resultEmpty),
    .o_Result_Rdack (resultRdack),
    .i_Feed_Full    (feedFull),
    .o_Feed_Wrreq   (feedWrreq),
    .o_Feed_Data    (feedData),
    .o_Fifo_Aclr    (fifoAclr),
    .o_Fb_We        (fbWe),
    .o_Fb_Addr      (fbAddr),
    .o_Fb_Data      (fbData),
    .o_Pass_Done    (passDone),
    .o_Pass_Count   (passCount)
  );

  task automatic checkOutput(input string tag, input logic [103:0] observed, input logic [103:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic empty, input logic full, input logic [103:0] data);
    resultEmpty = empty;
    feedFull    = full;
    resultData  = data;
  endtask

  task automatic initModel();
    modelPix     = 0;
    expFbWe      = 1'b0;
    expFbAddr    = 0;
    expFbData    = 8'h00;
    expPassDone  = 1'b0;
    expPassCount = 0;
  endtask

  // Starts on the negedge where reset was released; watches CLEAR and SEED
  task automatic seedPhase(input bit toggleFull, output int nAclr, output int nPush,
                           output int firstP, output int lastP, output int nBad);
    int   tail;
    logic full;
    nAclr = 0; nPush = 0; firstP = -1; lastP = -1; nBad = 0; tail = 0;
    for (int cyc = 0; cyc < 600 && tail < 3; cyc++) begin
      if (cyc > 0) @(negedge clk);
      full = toggleFull && (cyc % 3 == 2);
      applyStimulus(nPush >= PIX, full, {8'hC3, 32'd7, 32'd9, 32'd11});
      #1;
      if (fifoAclr) nAclr++;
      if (feedWrreq) begin
        nPush++;
        if (firstP < 0) firstP = cyc;
        lastP = cyc;
        if (feedData != '0 || full) nBad++;
      end
      if (resultRdack || fbWe) nBad++;
      if (nPush >= PIX) tail++;
    end
  endtask

  // One RUN cycle: checks last cycle's framebuffer write and this cycle's handshake
  task automatic runCycle(input logic empty, input logic full, input logic [7:0] px);
    logic [103:0] rec;
    logic         pop;
    rec = {px, 32'(modelPix % H), 32'(modelPix / H), 32'h0000_00A5 ^ 32'(modelPix)};
    @(negedge clk);
    applyStimulus(empty, full, rec);
    #1;
    pop = !empty && !full;
    checkOutput("fbWe", fbWe, expFbWe);
    checkOutput("fbAddr", fbAddr, expFbAddr);
    checkOutput("fbData", fbData, expFbData);
    checkOutput("passDone", passDone, expPassDone);
    checkOutput("passCount", passCount, expPassCount);
    checkOutput("rdack", resultRdack, pop);
    checkOutput("wrreq", feedWrreq, pop);
    if (pop) checkOutput("feedData", feedData, rec);
    expFbWe     = pop;
    expPassDone = pop && (modelPix == PIX - 1);
    if (pop) begin
      expFbAddr = modelPix;
      expFbData = px;
      if (modelPix == PIX - 1) expPassCount++;
      modelPix = (modelPix + 1) % PIX;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN = 1'b0;
    applyStimulus(1'b1, 1'b0, '0);
    #3;
    checkOutput("rstAclr", fifoAclr, 1'b1);
    checkOutput("rstFbWe", fbWe, 1'b0);
    checkOutput("rstFbAddr", fbAddr, 0);
    checkOutput("rstFbData", fbData, 0);
    checkOutput("rstPassDone", passDone, 1'b0);
    checkOutput("rstPassCount", passCount, 0);
    checkOutput("rstWrreq", feedWrreq, 1'b0);

    repeat (2) @(negedge clk);
    rstN = 1'b1;
    seedPhase(1'b0, aclrCycles, pushes, firstPush, lastPush, badCycles);
    checkOutput("seedAclrCycles", aclrCycles, 4);
    checkOutput("seedFirstPush", firstPush, 4);
    checkOutput("seedPushes", pushes, PIX);
    checkOutput("seedConsecutive", lastPush - firstPush + 1, PIX);
    checkOutput("seedBadCycles", badCycles, 0);

    @(posedge clk);
    #3 rstN = 1'b0;
    #1 checkOutput("reRstAclr", fifoAclr, 1'b1);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    seedPhase(1'b1, aclrCycles, pushes, firstPush, lastPush, badCycles);
    checkOutput("stallSeedAclrCycles", aclrCycles, 4);
    checkOutput("stallSeedFirstPush", firstPush, 4);
    checkOutput("stallSeedPushes", pushes, PIX);
    checkOutput("stallSeedBadCycles", badCycles, 0);

    initModel();
    for (int i = 0; i < H - 1; i++) runCycle(1'b0, 1'b0, 8'(i + 1));
    runCycle(1'b0, 1'b0, 8'h85);
    runCycle(1'b0, 1'b0, 8'h40);
    checkOutput("lineEndWe", fbWe, 1'b1);
    checkOutput("lineEndAddr", fbAddr, H - 1);
    checkOutput("lineEndData", fbData, 8'h85);
    runCycle(1'b1, 1'b0, 8'h00);
    checkOutput("nextLineAddr", fbAddr, H);
    checkOutput("nextLineData", fbData, 8'h40);

    repeat (10) runCycle(1'b0, 1'b1, 8'hEE);
    checkOutput("feedFullNoWe", fbWe, 1'b0);
    checkOutput("feedFullAddrHeld", fbAddr, H);
    runCycle(1'b1, 1'b1, 8'h00);

    for (int i = H + 1; i < PIX - 1; i++) begin
      if (i % 7 == 0) runCycle(1'b1, 1'b0, 8'h00);
      runCycle(1'b0, 1'b0, 8'(i));
    end
    runCycle(1'b0, 1'b0, 8'hFF);
    runCycle(1'b0, 1'b0, 8'h11);
    checkOutput("lastPixAddr", fbAddr, PIX - 1);
    checkOutput("lastPixDone", passDone, 1'b1);
    checkOutput("lastPixCount", passCount, 1);
    runCycle(1'b1, 1'b0, 8'h00);
    checkOutput("wrapAddr", fbAddr, 0);
    checkOutput("wrapData", fbData, 8'h11);
    checkOutput("wrapDoneClear", passDone, 1'b0);
    checkOutput("wrapCountHeld", passCount, 1);

    for (int i = 1; i < 20; i++) runCycle(1'b0, 1'b0, 8'(i + 8'h30));
    #2;
    applyStimulus(1'b0, 1'b0, {8'h77, 96'h0});
    rstN = 1'b0;
    #1;
    checkOutput("midRstFbWe", fbWe, 1'b0);
    checkOutput("midRstFbAddr", fbAddr, 0);
    checkOutput("midRstFbData", fbData, 0);
    checkOutput("midRstPassDone", passDone, 1'b0);
    checkOutput("midRstPassCount", passCount, 0);
    checkOutput("midRstAclr", fifoAclr, 1'b1);
    checkOutput("midRstRdack", resultRdack, 1'b0);
    checkOutput("midRstWrreq", feedWrreq, 1'b0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    seedPhase(1'b0, aclrCycles, pushes, firstPush, lastPush, badCycles);
    checkOutput("reseedAclrCycles", aclrCycles, 4);
    checkOutput("reseedPushes", pushes, PIX);
    checkOutput("reseedBadCycles", badCycles, 0);

    initModel();
    runCycle(1'b0, 1'b0, 8'h5A);
    runCycle(1'b1, 1'b0, 8'h00);
    checkOutput("reseedFirstAddr", fbAddr, 0);
    checkOutput("reseedFirstData", fbData, 8'h5A);
    checkOutput("reseedPassCount", passCount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
